uart_rx_fsm: RTL and testbench
==============================

# uart_rx_fsm

Receive-side frame sequencer for the UART RX path. It detects the start bit, times every bit with an oversampling edge counter, and enables data sampling and the parity checker at the correct edges. It checks start and stop bits, assembles the data word, and issues a one-cycle `data_valid` strobe per good frame. It sits between the RX pin synchroniser/majority sampler and the RX FIFO/register-file write logic.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, LSB first.
- `PRESC_W`, 6: width of the `prescale` input.
- `clk` in 1: RX clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_in` in 1: synchronised serial line; idle high.
- `prescale` in `PRESC_W`: oversampling ratio; legal values are 8, 16 and 32.
- `par_en` in 1: parity bit present in the frame.
- `sampled_bit` in 1: majority-voted bit from the sampler; valid from `edge_cnt == prescale/2+2`.
- `par_err` in 1: combinational error flag from the parity checker; read only while `par_chk_en` is high.
- `data_samp_en` out 1: sampler enable.
- `par_chk_en` out 1: parity checker enable.
- `edge_cnt` out `PRESC_W`: current oversampling edge, 0 .. prescale-1.
- `p_data` out `DATA_WIDTH`: received word; stable from `data_valid` until the next `data_valid`.
- `data_valid` out 1: one-cycle strobe for a good frame.
- `par_err_out` out 1: parity error flag for the last frame.
- `stp_err_out` out 1: stop-bit error flag for the last frame.
- `busy` out 1: a frame is in progress.

## Operation
- States are `IDLE`, `START`, `DATA`, `PARITY`, `STOP`. The encoding lives in the package.
- The edge counter increments every cycle outside `IDLE` and wraps from prescale-1 to 0. Each wrap increments `bit_cnt`.
- "Bit end" means `edge_cnt == prescale-1`. `prescale` is latched on entry to `START`; changing the input mid-frame has no effect.
- `IDLE`:
  - Counters are held at 0.
  - On `rx_in == 0`, go to `START` and clear `par_err_out` and `stp_err_out`.
- `START`:
  - `data_samp_en` is high.
  - At bit end, if `sampled_bit == 1` (glitch), return to `IDLE` with no flags and no strobe.
  - Otherwise go to `DATA`.
- `DATA`:
  - `data_samp_en` is high.
  - At each bit end, `sampled_bit` is shifted into `p_data` from the MSB side, giving LSB-first order.
  - After `DATA_WIDTH` bits, go to `PARITY` if `par_en`, else to `STOP`.
- `PARITY`:
  - `data_samp_en` is high.
  - `par_chk_en` is high only in the bit-end cycle; `par_err_out` registers `par_err` in that cycle.
  - Then go to `STOP`.
- `STOP`:
  - `data_samp_en` is high.
  - At bit end, `stp_err_out` registers `~sampled_bit` and the state returns to `IDLE`.
  - `data_valid` is registered: it goes high the cycle after the stop bit end, for one cycle, only if both error flags are 0.
  - On an error, `p_data` is not updated and no strobe is issued.
- `busy` is high in every state except `IDLE`.
- Back-to-back frames:
  - A start edge seen in the `data_valid` cycle is accepted; the next frame begins with no lost cycle.
  - `p_data` keeps its value until the next strobe. The shift register is internal; `p_data` is the output copy loaded at the strobe.
- `par_en` is sampled on entry to `START`.

## Timing
- Reset values: all outputs are 0, the state is `IDLE`, and all counters are 0.
- Reset deasserted mid-frame is not meaningful. Reset asserted mid-frame aborts the frame immediately with no strobe.
- Frame length from the `rx_in` fall to `data_valid` is (1 + DATA_WIDTH + par_en + 1)·prescale + 1 cycles.
- `par_chk_en` pulse width is exactly 1 cycle per frame.
- An illegal prescale (not 8, 16 or 32) gives undefined sampling, but the FSM must still return to `IDLE`: the counter wraps at the latched value.

## Configuration
- `UART_RX_ERR_CNT_EN` defined:
  - Adds output `err_cnt`, 8 bits, reset 0.
  - Increments once per frame with a parity or stop error, including a frame with both.
  - Saturates at 255.
  - Start glitches are not counted.
- Macro undefined: the port and its logic are absent. Behaviour is otherwise identical.

## Structure
- Package `uart_rx_pkg` holds:
  - the `rx_state_t` enum;
  - localparams for the legal prescale values;
  - `DATA_WIDTH_DEF = 8`.
- One sub-module, `edge_bit_counter`:
  - inputs `enable` and `prescale`;
  - outputs `edge_cnt`, `bit_cnt` and a `bit_end` flag.
- The FSM and data assembly stay in `uart_rx_fsm`.

## Test plan
- prescale=8, par_en=0, frame 0x5A with a good stop bit -> `data_valid` 81 cycles after the start fall, `p_data = 0x5A`, both error flags 0.
- prescale=16, par_en=1, 0xA3 with correct parity (checker `par_err = 0`) -> `par_chk_en` pulses once at the bit end of bit 9; `data_valid` high; `p_data = 0xA3`.
- Same frame with `par_err = 1` forced in the `par_chk_en` cycle -> `par_err_out = 1`, no `data_valid`, `p_data` unchanged.
- A low pulse on `rx_in` shorter than half a bit (`sampled_bit = 1` at the start bit end) -> return to `IDLE` after `prescale` cycles, no flags, no strobe.
- Stop bit sampled as 0 -> `stp_err_out = 1`, no strobe. With the macro defined, `err_cnt` goes 0→1. 300 such frames -> `err_cnt = 255`.
- Two back-to-back frames 0x01 then 0xFF with the second start edge in the `data_valid` cycle -> two strobes with the correct words. `reset_n` pulsed mid-frame -> all outputs 0 and no strobe.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESC_W_DEF    = 6;

    localparam logic [5:0] PRESC_8  = 6'd8;
    localparam logic [5:0] PRESC_16 = 6'd16;
    localparam logic [5:0] PRESC_32 = 6'd32;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the RX sampler/parity checker side and the frame sequencer.
// Optional err_cnt member is present when UART_RX_ERR_CNT_EN is defined.
interface uart_rx_fsm_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESC_W    = PRESC_W_DEF
);
    logic                  rx_in;
    logic [PRESC_W-1:0]    prescale;
    logic                  par_en;
    logic                  sampled_bit;
    logic                  par_err;
    logic                  data_samp_en;
    logic                  par_chk_en;
    logic [PRESC_W-1:0]    edge_cnt;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_err_out;
    logic                  stp_err_out;
    logic                  busy;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0]            err_cnt;
`endif

    modport master (
`ifdef UART_RX_ERR_CNT_EN
        input  err_cnt,
`endif
        output rx_in, prescale, par_en, sampled_bit, par_err,
        input  data_samp_en, par_chk_en, edge_cnt, p_data, data_valid,
        input  par_err_out, stp_err_out, busy
    );

    modport slave (
`ifdef UART_RX_ERR_CNT_EN
        output err_cnt,
`endif
        input  rx_in, prescale, par_en, sampled_bit, par_err,
        output data_samp_en, par_chk_en, edge_cnt, p_data, data_valid,
        output par_err_out, stp_err_out, busy
    );

endinterface

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Oversampling edge counter with bit counter; wraps at the latched prescale.
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF,
    parameter int BIT_W   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]   bit_cnt,
    output logic               bit_end
);

    logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;

    // bit_end must not depend on enable: the FSM derives enable from its next state
    assign bit_end  = (edge_cnt_q == (prescale - PRESC_W'(1)));
    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

    // next-count logic: hold at zero when disabled, wrap at bit end
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (!enable) begin
            edge_cnt_d = {PRESC_W{1'b0}};
            bit_cnt_d  = {BIT_W{1'b0}};
        end else if (bit_end) begin
            edge_cnt_d = {PRESC_W{1'b0}};
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
        end else begin
            edge_cnt_d = edge_cnt_q + PRESC_W'(1);
        end
    end

    // counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cnt_q <= {PRESC_W{1'b0}};
            bit_cnt_q  <= {BIT_W{1'b0}};
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART RX frame sequencer: start/data/parity/stop sequencing, word assembly, error flags.
// Define UART_RX_ERR_CNT_EN to add the saturating 8-bit frame error counter err_cnt.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESC_W    = PRESC_W_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    uart_rx_fsm_if.slave  bus
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 4);

    rx_state_t             state_q, state_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  busy_q, busy_d;
    logic [PRESC_W-1:0]    edge_cnt_s;
    logic [BIT_W-1:0]      bit_cnt_s;
    logic                  bit_end_s;
    logic                  cnt_en_s;
    logic                  stop_end_s;

    // counter is cleared on the edge that returns to IDLE so IDLE always sees zeros
    assign cnt_en_s   = (state_q != IDLE) && (state_d != IDLE);
    assign stop_end_s = (state_q == STOP) && bit_end_s;

    edge_bit_counter #(
        .PRESC_W (PRESC_W),
        .BIT_W   (BIT_W)
    ) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (cnt_en_s),
        .prescale (presc_q),
        .edge_cnt (edge_cnt_s),
        .bit_cnt  (bit_cnt_s),
        .bit_end  (bit_end_s)
    );

    // next-state, word assembly and flag logic
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        par_en_d  = par_en_q;
        shift_d   = shift_q;
        p_data_d  = p_data_q;
        dv_d      = 1'b0;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        case (state_q)
            IDLE: begin
                if (!bus.rx_in) begin
                    state_d   = START;
                    presc_d   = bus.prescale;
                    par_en_d  = bus.par_en;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d = bus.sampled_bit ? IDLE : DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_d = {bus.sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_s == BIT_W'(DATA_WIDTH)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    par_err_d = bus.par_err;
                    state_d   = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    stp_err_d = ~bus.sampled_bit;
                    state_d   = IDLE;
                    if (bus.sampled_bit && !par_err_q) begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end else begin
                        dv_d = 1'b0;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // state and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            presc_q   <= {PRESC_W{1'b0}};
            par_en_q  <= 1'b0;
            shift_q   <= {DATA_WIDTH{1'b0}};
            p_data_q  <= {DATA_WIDTH{1'b0}};
            dv_q      <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            par_en_q  <= par_en_d;
            shift_q   <= shift_d;
            p_data_q  <= p_data_d;
            dv_q      <= dv_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.data_samp_en = busy_q;
    assign bus.par_chk_en   = (state_q == PARITY) && bit_end_s;
    assign bus.edge_cnt     = edge_cnt_s;
    assign bus.p_data       = p_data_q;
    assign bus.data_valid   = dv_q;
    assign bus.par_err_out  = par_err_q;
    assign bus.stp_err_out  = stp_err_q;

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // one count per errored frame, saturating
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (stop_end_s && (!bus.sampled_bit || par_err_q) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // error counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm with a strobe scoreboard; err_cnt checks under UART_RX_ERR_CNT_EN.
module tb_uart_rx_fsm;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;

    uart_rx_fsm_if #(.DATA_WIDTH(8), .PRESC_W(6)) bus ();

    uart_rx_fsm #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // sampler model: majority output lags the line by one cycle
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.sampled_bit <= 1'b1;
        else          bus.sampled_bit <= bus.rx_in;
    end

    int errors = 0;
    int checks = 0;
    int p_cur = 8;
    int fall_cyc = 0;
    int dv_count = 0;
    int last_dv_cyc = 0;
    int prev_dv_cyc = 0;
    int pc_count = 0;
    int last_pc_cyc = 0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] exp_q[$];

    task automatic monitor();
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (bus.data_valid === 1'b1) begin
                dv_count++;
                prev_dv_cyc = last_dv_cyc;
                last_dv_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe p_data=%h required no strobe", bus.p_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.p_data !== exp) begin
                        errors++;
                        $display("FAIL strobe_word p_data=%h required %h", bus.p_data, exp);
                    end
                end
            end
            if (bus.par_chk_en === 1'b1) begin
                pc_count++;
                last_pc_cyc = cyc;
            end
        end
    endtask

    // caller must be #1 after a rising edge
    task automatic drive_bit(input logic b);
        bus.rx_in = b;
        repeat (p_cur) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stp);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stp);
        bus.rx_in = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int p, input logic pen);
        p_cur        = p;
        bus.prescale = 6'(p);
        bus.par_en   = pen;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.rx_in    = 1'b1;
        bus.par_err  = 1'b0;
        set_mode(8, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.data_valid !== 1'b0)   begin errors++; $display("FAIL rst_data_valid got %b want 0", bus.data_valid); end
        checks++; if (bus.busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        checks++; if (bus.data_samp_en !== 1'b0) begin errors++; $display("FAIL rst_samp_en got %b want 0", bus.data_samp_en); end
        checks++; if (bus.par_chk_en !== 1'b0)   begin errors++; $display("FAIL rst_par_chk_en got %b want 0", bus.par_chk_en); end
        checks++; if (bus.edge_cnt !== 6'd0)     begin errors++; $display("FAIL rst_edge_cnt got %0d want 0", bus.edge_cnt); end
        checks++; if (bus.p_data !== 8'h00)      begin errors++; $display("FAIL rst_p_data got %h want 00", bus.p_data); end
        checks++; if (bus.par_err_out !== 1'b0)  begin errors++; $display("FAIL rst_par_err got %b want 0", bus.par_err_out); end
        checks++; if (bus.stp_err_out !== 1'b0)  begin errors++; $display("FAIL rst_stp_err got %b want 0", bus.stp_err_out); end
`ifdef UART_RX_ERR_CNT_EN
        checks++; if (bus.err_cnt !== 8'd0)      begin errors++; $display("FAIL rst_err_cnt got %0d want 0", bus.err_cnt); end
`endif
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int dv0;
        set_mode(8, 1'b0);
        dv0 = dv_count;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        last_good = 8'h5A;
        checks++; if (dv_count !== dv0 + 1)            begin errors++; $display("FAIL basic_strobes got %0d want %0d", dv_count - dv0, 1); end
        checks++; if (last_dv_cyc - fall_cyc !== 81)   begin errors++; $display("FAIL basic_latency got %0d want 81", last_dv_cyc - fall_cyc); end
        checks++; if (bus.p_data !== 8'h5A)            begin errors++; $display("FAIL basic_p_data got %h want 5a", bus.p_data); end
        checks++; if (bus.par_err_out !== 1'b0 || bus.stp_err_out !== 1'b0) begin errors++; $display("FAIL basic_flags got %b%b want 00", bus.par_err_out, bus.stp_err_out); end
        checks++; if (bus.busy !== 1'b0)               begin errors++; $display("FAIL basic_idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_stop_err();
        int dv0;
        set_mode(8, 1'b0);
        dv0 = dv_count;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.stp_err_out !== 1'b1)  begin errors++; $display("FAIL stop_err_flag got %b want 1", bus.stp_err_out); end
        @(posedge clk); #1;
        checks++; if (dv_count !== dv0)          begin errors++; $display("FAIL stop_err_strobe got %0d want 0", dv_count - dv0); end
        checks++; if (bus.p_data !== last_good)  begin errors++; $display("FAIL stop_err_p_data got %h want %h", bus.p_data, last_good); end
`ifdef UART_RX_ERR_CNT_EN
        checks++; if (bus.err_cnt !== 8'd1)      begin errors++; $display("FAIL stop_err_cnt got %0d want 1", bus.err_cnt); end
`endif
    endtask

    task automatic test_glitch();
        int dv0;
        set_mode(8, 1'b0);
        dv0 = dv_count;
        bus.rx_in = 1'b0;
        repeat (2) @(posedge clk); #1;
        bus.rx_in = 1'b1;
        checks++; if (bus.busy !== 1'b1 || bus.data_samp_en !== 1'b1) begin errors++; $display("FAIL glitch_in_start busy/samp got %b%b want 11", bus.busy, bus.data_samp_en); end
        repeat (p_cur - 1) @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0)        begin errors++; $display("FAIL glitch_return_idle busy got %b want 0", bus.busy); end
        checks++; if (bus.edge_cnt !== 6'd0)    begin errors++; $display("FAIL glitch_edge_cnt got %0d want 0", bus.edge_cnt); end
        checks++; if (bus.par_err_out !== 1'b0 || bus.stp_err_out !== 1'b0) begin errors++; $display("FAIL glitch_flags got %b%b want 00", bus.par_err_out, bus.stp_err_out); end
        repeat (4) @(posedge clk); #1;
        checks++; if (dv_count !== dv0)         begin errors++; $display("FAIL glitch_strobe got %0d want 0", dv_count - dv0); end
`ifdef UART_RX_ERR_CNT_EN
        checks++; if (bus.err_cnt !== 8'd1)     begin errors++; $display("FAIL glitch_err_cnt got %0d want 1", bus.err_cnt); end
`endif
    endtask

    task automatic test_parity(input logic force_err);
        int dv0;
        int pc0;
        logic [7:0] d;
        d = 8'hA3;
        set_mode(16, 1'b1);
        dv0 = dv_count;
        pc0 = pc_count;
        bus.par_err = force_err;
        if (!force_err) exp_q.push_back(d);
        send_frame(d, 1'b1, ^d, 1'b1);
        bus.par_err = 1'b0;
        @(posedge clk); #1;
        checks++; if (pc_count !== pc0 + 1)            begin errors++; $display("FAIL par_chk_pulses got %0d want 1", pc_count - pc0); end
        checks++; if (last_pc_cyc - fall_cyc !== 160)  begin errors++; $display("FAIL par_chk_time got %0d want 160", last_pc_cyc - fall_cyc); end
        checks++; if (bus.par_err_out !== force_err)   begin errors++; $display("FAIL par_err_out got %b want %b", bus.par_err_out, force_err); end
        checks++; if (bus.p_data !== 8'hA3)            begin errors++; $display("FAIL par_p_data got %h want a3", bus.p_data); end
        if (force_err) begin
            checks++; if (dv_count !== dv0)            begin errors++; $display("FAIL par_err_strobe got %0d want 0", dv_count - dv0); end
`ifdef UART_RX_ERR_CNT_EN
            checks++; if (bus.err_cnt !== 8'd2)        begin errors++; $display("FAIL par_err_cnt got %0d want 2", bus.err_cnt); end
`endif
        end else begin
            checks++; if (dv_count !== dv0 + 1)        begin errors++; $display("FAIL par_good_strobe got %0d want 1", dv_count - dv0); end
            checks++; if (last_dv_cyc - fall_cyc !== 177) begin errors++; $display("FAIL par_good_latency got %0d want 177", last_dv_cyc - fall_cyc); end
            last_good = d;
        end
    endtask

    task automatic test_back_to_back();
        int dv0;
        set_mode(8, 1'b0);
        dv0 = dv_count;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        last_good = 8'hFF;
        checks++; if (dv_count !== dv0 + 2)              begin errors++; $display("FAIL b2b_strobes got %0d want 2", dv_count - dv0); end
        checks++; if (last_dv_cyc - prev_dv_cyc !== 81)  begin errors++; $display("FAIL b2b_gap got %0d want 81", last_dv_cyc - prev_dv_cyc); end
        checks++; if (bus.p_data !== 8'hFF)              begin errors++; $display("FAIL b2b_p_data got %h want ff", bus.p_data); end
    endtask

    task automatic test_reset_mid();
        int dv0;
        set_mode(8, 1'b0);
        dv0 = dv_count;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        reset_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.data_samp_en !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b%b want 00", bus.busy, bus.data_samp_en); end
        checks++; if (bus.edge_cnt !== 6'd0)   begin errors++; $display("FAIL rmid_edge_cnt got %0d want 0", bus.edge_cnt); end
        checks++; if (bus.p_data !== 8'h00)    begin errors++; $display("FAIL rmid_p_data got %h want 00", bus.p_data); end
        checks++; if (bus.data_valid !== 1'b0 || bus.par_err_out !== 1'b0 || bus.stp_err_out !== 1'b0) begin errors++; $display("FAIL rmid_flags got %b%b%b want 000", bus.data_valid, bus.par_err_out, bus.stp_err_out); end
        bus.rx_in = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3 * p_cur) @(posedge clk); #1;
        last_good = 8'h00;
        checks++; if (dv_count !== dv0)        begin errors++; $display("FAIL rmid_strobe got %0d want 0", dv_count - dv0); end
        checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL rmid_after_busy got %b want 0", bus.busy); end
    endtask

`ifdef UART_RX_ERR_CNT_EN
    task automatic test_err_cnt_sat();
        set_mode(8, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.err_cnt !== 8'd1)   begin errors++; $display("FAIL sat_first got %0d want 1", bus.err_cnt); end
        for (int i = 1; i < 300; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        checks++; if (bus.err_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got %0d want 255", bus.err_cnt); end
    endtask
`endif

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_stop_err();
        test_glitch();
        test_parity(1'b0);
        test_parity(1'b1);
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_ERR_CNT_EN
        test_err_cnt_sat();
`endif
        repeat (4) @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes pending=%0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
